mac_accum_stage: RTL

//  Accumulation stage directly downstream of the 8-bit registered multiplier.

---
 rtl/mac_accum_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mac_accum_stage.sv
// mac_accum_stage
// Sums N_TERMS consecutive unsigned products from the registered multiplier
// into one ACC_W-bit result. The result is offered downstream on a valid/ready
// handshake. A sticky flag records any carry out of the accumulator MSB.
//
// Parameter limits: ACC_W >= PROD_W and 1 <= N_TERMS <= 255. The term counter
// is 8 bits wide, so N_TERMS cannot exceed 255.
module mac_accum_stage #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic [7:0]        term_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter value at which the incoming product is the final term.
  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  // Zero-extension width that brings the product up to ACC_W+1 bits, so the
  // carry out of the accumulator lands in the top bit of the sum.
  localparam int EXT_W = ACC_W - PROD_W + 1;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic               ovf_reg, ovf_next;
  logic               busy_reg, busy_next;
  logic               valid_reg, valid_next;
  logic [ACC_W:0]     sum_ext;

  // Wide sum: bit ACC_W is the carry out of the modulo-2^ACC_W accumulator.
  assign sum_ext = {1'b0, acc_reg} + {{EXT_W{1'b0}}, product};

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic. busy and acc_valid are computed one cycle ahead so they
  // come straight from flops and change together with the state register.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    busy_next  = busy_reg;
    valid_next = valid_reg;

    unique case (state_reg)
      IDLE: begin
        // The previous result stays on acc_out until a new run begins.
        if (start) begin
          state_next = ACCUM;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          busy_next  = 1'b1;
          valid_next = 1'b0;
        end
      end

      ACCUM: begin
        // start is deliberately ignored here. An accumulation always runs to
        // completion. Gaps in prod_valid simply stall the run.
        if (prod_valid) begin
          acc_next = sum_ext[ACC_W-1:0];
          cnt_next = cnt_reg + 8'd1;
          ovf_next = ovf_reg | sum_ext[ACC_W];
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
            busy_next  = 1'b0;
            valid_next = 1'b1;
          end
        end
      end

      DONE: begin
        // The result is frozen until the consumer takes it. A start pulse
        // seen on the transfer cycle does not chain into a new run.
        if (acc_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign busy      = busy_reg;
  assign acc_valid = valid_reg;
  assign acc_out   = acc_reg;
  assign overflow  = ovf_reg;
  assign term_cnt  = cnt_reg;

endmodule
